// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin frame arbiter in front of uart_core's write port.
// A grant is held from arbitration until the requester's req_last byte is
// accepted, or until TIMEOUT consecutive starved cycles force a release.
module uart_tx_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DBIT    = 8,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TO_BIT  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ*DBIT-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [DBIT-1:0]      w_data,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state;
  logic [IW-1:0]   g_idx;
  logic [IW-1:0]   last_ptr;
  logic [TO_BIT-1:0] to_cnt;

  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand_idx;
  logic            win_found;
  int unsigned     cand;
  logic            accept;
  logic            starved;

  // Round-robin search starting one past the previous owner, with wrap-around.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand     = (32'(last_ptr) + k) % NREQ;
      cand_idx = IW'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Write-port outputs, decoded from the registered grant and live inputs.
  always_comb begin
    busy      = (state == XFER);
    accept    = busy && req_valid[g_idx] && !tx_full;
    starved   = busy && !req_valid[g_idx];
    wr_uart   = accept;
    req_ready = accept ? grant : '0;
    w_data    = accept ? req_data[32'(g_idx)*DBIT +: DBIT] : '0;
  end

  // Arbitration FSM: grant, owner index, priority pointer and starvation timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      g_idx       <= '0;
      last_ptr    <= IW'(NREQ - 1);
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant  <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            g_idx  <= win_idx;
            to_cnt <= '0;
            state  <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            to_cnt <= '0;
            if (req_last[g_idx]) begin
              last_ptr <= g_idx;
              grant    <= '0;
              state    <= IDLE;
            end
          end else if (starved) begin
            // to_cnt holds the count of starved cycles already elapsed,
            // so this cycle is the TIMEOUT-th when it reads TIMEOUT-1.
            if (to_cnt == TO_BIT'(TIMEOUT - 1)) begin
              to_cnt      <= '0;
              last_ptr    <= g_idx;
              grant       <= '0;
              state       <= IDLE;
              timeout_err <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a frame-level reference model.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int DBIT    = 8;
  localparam int TIMEOUT = 8;
  localparam int TO_BIT  = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_last;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_full;
  logic                 wr_uart;
  logic [DBIT-1:0]      w_data;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic                 timeout_err;

  uart_tx_arbiter #(
    .NREQ(NREQ), .DBIT(DBIT), .TIMEOUT(TIMEOUT), .TO_BIT(TO_BIT)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data), .grant(grant), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Requester frame queues: entry = {last, data}
  bit [8:0]        fq[NREQ][$];
  bit [NREQ-1:0]   en;

  // Reference model state
  int m_owner;   // -1 when nobody owns the TX path
  int m_last;    // previous owner, lowest priority next time
  int m_starve;  // consecutive starved cycles of the owner
  bit m_pulse;

  int          wlog_idx[$];
  bit [7:0]    wlog_data[$];
  int          to_pulses;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_last   = NREQ - 1;
    m_starve = 0;
    m_pulse  = 0;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NREQ; i++) fq[i].delete();
  endtask

  function automatic bit idle_now();
    bit r = (m_owner < 0);
    for (int i = 0; i < NREQ; i++) if (fq[i].size() != 0) r = 0;
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = en[i] && (fq[i].size() > 0);
      if (req_valid[i]) begin
        req_last[i]                = fq[i][0][8];
        req_data[i*DBIT +: DBIT]   = fq[i][0][7:0];
      end else begin
        req_last[i]                = 1'($urandom);
        req_data[i*DBIT +: DBIT]   = 8'($urandom);
      end
    end
  endtask

  task automatic compare();
    int g;
    bit acc;
    logic [NREQ-1:0] eg;
    logic [7:0] ed;
    g   = m_owner;
    acc = (g >= 0) && req_valid[g] && !tx_full;
    eg  = (g >= 0) ? NREQ'(1 << g) : '0;
    ed  = acc ? fq[g][0][7:0] : 8'h00;
    check("grant", 32'(grant), 32'(eg));
    check("busy", 32'(busy), 32'(g >= 0));
    check("wr_uart", 32'(wr_uart), 32'(acc));
    check("req_ready", 32'(req_ready), acc ? 32'(eg) : 32'd0);
    check("w_data", 32'(w_data), 32'(ed));
    check("timeout_err", 32'(timeout_err), 32'(m_pulse));
    if (wr_uart) begin
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) wlog_idx.push_back(i);
      wlog_data.push_back(w_data);
    end
    if (timeout_err) to_pulses++;
  endtask

  task automatic model_update();
    bit found = 0;
    bit l;
    m_pulse = 0;
    if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c = (m_last + k) % NREQ;
        if (!found && req_valid[c]) begin
          found    = 1;
          m_owner  = c;
          m_starve = 0;
        end
      end
    end else if (req_valid[m_owner] && !tx_full) begin
      l = fq[m_owner][0][8];
      void'(fq[m_owner].pop_front());
      m_starve = 0;
      if (l) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (!req_valid[m_owner]) begin
      m_starve++;
      if (m_starve == TIMEOUT) begin
        m_last   = m_owner;
        m_owner  = -1;
        m_pulse  = 1;
        m_starve = 0;
      end
    end
  endtask

  // One clock cycle: drive, compare before the edge, advance the model, wait.
  task automatic tick();
    drive();
    #1 compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    bit done = idle_now();
    while (!done && n < max) begin
      tick();
      n++;
      done = idle_now();
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  task automatic clear_logs();
    wlog_idx.delete();
    wlog_data.delete();
    to_pulses = 0;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_full   = 1'b0;
    clear_queues();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_uart", 32'(wr_uart), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_w_data", 32'(w_data), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;
  endtask

  task automatic push_frame(input int r, input int len);
    for (int b = 0; b < len; b++) fq[r].push_back({(b == len - 1), 8'($urandom)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rr[8];
    int exp_to[3];
    en = '1;
    apply_reset();

    // Single 3-byte frame from requester 2
    clear_logs();
    fq[2].push_back({1'b0, 8'hA1});
    fq[2].push_back({1'b0, 8'hA2});
    fq[2].push_back({1'b1, 8'hA3});
    run_until_idle(20);
    check("t1_nbytes", 32'(wlog_data.size()), 32'd3);
    if (wlog_data.size() == 3) begin
      check("t1_b0", 32'(wlog_data[0]), 32'hA1);
      check("t1_b1", 32'(wlog_data[1]), 32'hA2);
      check("t1_b2", 32'(wlog_data[2]), 32'hA3);
      check("t1_src", 32'(wlog_idx[2]), 32'd2);
    end

    // Round-robin fairness from reset
    apply_reset();
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) fq[i].push_back({1'b1, 8'(8'h10 + i)});
    run_until_idle(40);
    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
    check("rr_count", 32'(wlog_idx.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < wlog_idx.size()) check("rr_order", 32'(wlog_idx[k]), 32'(exp_rr[k]));

    // Back-pressure: 5 stalled cycles, then 7 starved ones (no timeout due)
    clear_logs();
    fq[1].push_back({1'b0, 8'hB1});
    fq[1].push_back({1'b0, 8'hB2});
    fq[1].push_back({1'b1, 8'hB3});
    tick();
    tick();
    tx_full = 1'b1;
    repeat (5) tick();
    tx_full = 1'b0;
    en[1] = 1'b0;
    repeat (7) tick();
    en[1] = 1'b1;
    run_until_idle(20);
    check("bp_no_timeout", 32'(to_pulses), 32'd0);
    check("bp_nbytes", 32'(wlog_data.size()), 32'd3);
    if (wlog_data.size() == 3) check("bp_b1", 32'(wlog_data[1]), 32'hB2);

    // Starvation timeout; the timed-out requester then yields to requester 3
    clear_logs();
    fq[2].push_back({1'b0, 8'hC1});
    fq[2].push_back({1'b1, 8'hC2});
    fq[3].push_back({1'b1, 8'hD1});
    tick();
    tick();
    en[2] = 1'b0;
    repeat (TIMEOUT) tick();
    en[2] = 1'b1;
    run_until_idle(40);
    check("to_pulses", 32'(to_pulses), 32'd1);
    exp_to = '{2, 3, 2};
    check("to_count", 32'(wlog_idx.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < wlog_idx.size()) check("to_order", 32'(wlog_idx[k]), 32'(exp_to[k]));

    // Async reset mid-frame, then a simultaneous request from everyone
    clear_logs();
    fq[0].push_back({1'b0, 8'hE0});
    fq[0].push_back({1'b0, 8'hE1});
    fq[0].push_back({1'b0, 8'hE2});
    fq[0].push_back({1'b1, 8'hE3});
    fq[1].push_back({1'b1, 8'hF1});
    tick();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("ar_grant", 32'(grant), 32'd0);
    check("ar_wr_uart", 32'(wr_uart), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_req_ready", 32'(req_ready), 32'd0);
    clear_queues();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    for (int i = 0; i < NREQ; i++) fq[i].push_back({1'b1, 8'(8'hE8 + i)});
    run_until_idle(20);
    check("ar_count", 32'(wlog_idx.size()), 32'd4);
    if (wlog_idx.size() > 0) check("ar_first", 32'(wlog_idx[0]), 32'd0);

    // Randomized traffic with back-pressure and requesters pausing mid-frame
    clear_logs();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(5) == 0) begin
        int r = $urandom_range(NREQ - 1);
        if (fq[r].size() < 8) push_frame(r, $urandom_range(4, 1));
      end
      tx_full = ($urandom_range(3) == 0);
      for (int i = 0; i < NREQ; i++) if ($urandom_range(15) == 0) en[i] = ~en[i];
      tick();
    end
    en = '1;
    tx_full = 1'b0;
    run_until_idle(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
